arc4_crack_dispatch: RTL and testbench

- Parametrised key-search dispatcher for the ARC4 cracking datapath.
- Partitions the key space into fixed-size chunks and issues them to `NUM_CORES` crack cores, replacing the fixed two-core split.
- Collects per-chunk results and stops all cores on the first hit.
- Reports the recovered key, or exhaustion, to the top level through the standard rdy/en handshake.

---
 rtl/arc4_crack_pkg.sv | 23 ++
 rtl/arc4_core_pick.sv | 25 ++
 rtl/arc4_crack_dispatch.sv | 160 ++++++++++++++++
 tb/tb_arc4_crack_dispatch.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/arc4_crack_pkg.sv
// Shared types and helpers for the ARC4 key-search dispatcher.
// Included by arc4_crack_dispatch and arc4_core_pick.
package arc4_crack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        DRAIN,
        FINISH
    } dispatch_state_t;

    localparam int DEFAULT_CHUNK_LOG2 = 16;
    localparam int CHUNK_SIZE = 1 << DEFAULT_CHUNK_LOG2;

    // Width of a core index; never below one bit so a single-core build still has an index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/arc4_core_pick.sv
// Lowest-index priority select over a core mask.
// Used for both free-core dispatch and found-key priority.
module arc4_core_pick
    import arc4_crack_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  mask,
    output logic          valid,
    output logic [IW-1:0] idx
);

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask[i]) begin
                valid = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/arc4_crack_dispatch.sv
// Key-space dispatcher: hands fixed-size chunks to NUM_CORES crack cores and stops on first hit.
// Optional performance counters are enabled by defining ARC4_DISPATCH_PERF_EN.
module arc4_crack_dispatch
    import arc4_crack_pkg::*;
#(
    parameter int NUM_CORES  = 2,
    parameter int KEY_W      = 24,
    parameter int CHUNK_LOG2 = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic                       rdy,
    output logic                       key_valid,
    output logic [KEY_W-1:0]           key,
    output logic                       done,
    output logic [NUM_CORES-1:0]       core_en,
    output logic [NUM_CORES*KEY_W-1:0] core_base,
    output logic [NUM_CORES-1:0]       core_abort,
    input  logic [NUM_CORES-1:0]       core_rdy,
    input  logic [NUM_CORES-1:0]       core_done,
    input  logic [NUM_CORES-1:0]       core_found,
    input  logic [NUM_CORES*KEY_W-1:0] core_key
`ifdef ARC4_DISPATCH_PERF_EN
    ,
    output logic [31:0]                perf_cycles,
    output logic [KEY_W-CHUNK_LOG2:0]  perf_chunks
`endif
);

    localparam int IW = clog2(NUM_CORES);
    localparam logic [KEY_W:0] STEP = (KEY_W + 1)'(1) << CHUNK_LOG2;

    dispatch_state_t        state;
    logic [NUM_CORES-1:0]   busy;
    logic [NUM_CORES-1:0]   aborted;
    logic [KEY_W-1:0]       next_base;
    logic                   exhausted;

    logic [NUM_CORES-1:0]   found_mask;
    logic [NUM_CORES-1:0]   busy_after_done;
    logic [NUM_CORES-1:0]   free_mask;
    logic [NUM_CORES-1:0]   pick_onehot;
    logic                   pick_valid;
    logic [IW-1:0]          pick_idx;
    logic                   found_valid;
    logic [IW-1:0]          found_idx;
    logic [KEY_W-1:0]       found_key;
    logic [KEY_W:0]         base_sum;
    logic                   dispatch_go;

    arc4_core_pick #(.N(NUM_CORES), .IW(IW)) u_pick_free (
        .mask  (free_mask),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    arc4_core_pick #(.N(NUM_CORES), .IW(IW)) u_pick_found (
        .mask  (found_mask),
        .valid (found_valid),
        .idx   (found_idx)
    );

    // Dones from cores we never dispatched to are ignored; a hit suppresses dispatch that cycle.
    always_comb begin
        found_mask      = core_done & core_found & busy;
        busy_after_done = busy & ~core_done;
        free_mask       = core_rdy & ~busy;
        base_sum        = {1'b0, next_base} + STEP;
        dispatch_go     = (state == DISPATCH) && pick_valid && !exhausted && !found_valid;
        pick_onehot     = '0;
        found_key       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pick_valid && pick_idx == IW'(i)) pick_onehot[i] = 1'b1;
            if (found_idx == IW'(i)) found_key = core_key[i*KEY_W +: KEY_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rdy        <= 1'b1;
            key_valid  <= 1'b0;
            key        <= '0;
            done       <= 1'b0;
            core_en    <= '0;
            core_abort <= '0;
            core_base  <= '0;
            busy       <= '0;
            aborted    <= '0;
            next_base  <= '0;
            exhausted  <= 1'b0;
        end else begin
            core_en    <= '0;
            core_abort <= '0;
            case (state)
                IDLE: begin
                    if (en) begin
                        done      <= 1'b0;
                        key_valid <= 1'b0;
                        next_base <= '0;
                        exhausted <= 1'b0;
                        busy      <= '0;
                        aborted   <= '0;
                        rdy       <= 1'b0;
                        state     <= DISPATCH;
                    end
                end
                DISPATCH: begin
                    if (found_valid) begin
                        // Aborted cores are no longer tracked as busy; DRAIN waits on their rdy instead.
                        key        <= found_key;
                        key_valid  <= 1'b1;
                        core_abort <= busy_after_done;
                        aborted    <= busy_after_done;
                        busy       <= '0;
                        state      <= DRAIN;
                    end else if (dispatch_go) begin
                        core_en <= pick_onehot;
                        for (int i = 0; i < NUM_CORES; i++) begin
                            if (pick_onehot[i]) core_base[i*KEY_W +: KEY_W] <= next_base;
                        end
                        busy                   <= busy_after_done | pick_onehot;
                        {exhausted, next_base} <= base_sum;
                    end else begin
                        busy <= busy_after_done;
                        if (exhausted && busy_after_done == '0) state <= FINISH;
                    end
                end
                DRAIN: begin
                    if ((aborted & ~core_rdy) == '0) state <= FINISH;
                end
                FINISH: begin
                    done  <= 1'b1;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARC4_DISPATCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_chunks <= '0;
        end else if (state == IDLE) begin
            if (en) begin
                perf_cycles <= '0;
                perf_chunks <= '0;
            end
        end else begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
            if (dispatch_go) perf_chunks <= perf_chunks + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arc4_crack_dispatch.sv
// Self-checking bench for arc4_crack_dispatch with two behavioural crack cores.
// Expected chunk bases and search results are queued up front and popped as the DUT produces them.
module tb_arc4_crack_dispatch;

    localparam int NC = 2;
    localparam int KW = 24;
    localparam int CL = 22;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic            rdy;
    logic            key_valid;
    logic [KW-1:0]   key;
    logic            done;
    logic [NC-1:0]   core_en;
    logic [NC*KW-1:0] core_base;
    logic [NC-1:0]   core_abort;
    logic [NC-1:0]   core_rdy   = '1;
    logic [NC-1:0]   core_done  = '0;
    logic [NC-1:0]   core_found = '0;
    logic [NC*KW-1:0] core_key  = '0;
`ifdef ARC4_DISPATCH_PERF_EN
    logic [31:0]     perf_cycles;
    logic [KW-CL:0]  perf_chunks;
`endif

    arc4_crack_dispatch #(.NUM_CORES(NC), .KEY_W(KW), .CHUNK_LOG2(CL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rdy        (rdy),
        .key_valid  (key_valid),
        .key        (key),
        .done       (done),
        .core_en    (core_en),
        .core_base  (core_base),
        .core_abort (core_abort),
        .core_rdy   (core_rdy),
        .core_done  (core_done),
        .core_found (core_found),
        .core_key   (core_key)
`ifdef ARC4_DISPATCH_PERF_EN
        ,
        .perf_cycles (perf_cycles),
        .perf_chunks (perf_chunks)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          kv;
        logic [KW-1:0] key;
    } res_t;

    logic [KW-1:0] base_q[$];
    res_t          res_q[$];
    int            compared   = 0;
    int            mismatched = 0;

    int            lat[NC];
    logic          hit[NC];
    logic [KW-1:0] hit_key[NC];
    int            cnt_m[NC];
    int            drain_m[NC];
    logic          busy_m[NC];
    logic [NC-1:0] abort_seen = '0;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic waitDone();
        res_t r;
        for (int c = 0; c < 2000; c++) begin
            if (done) break;
            @(negedge clk);
        end
        checkOutput("done_seen", done, 1);
        checkOutput("rdy_with_done", rdy, 1);
        checkOutput("base_queue_drained", base_q.size(), 0);
        if (res_q.size() == 0) begin
            checkOutput("result_queue_empty", 1, 0);
        end else begin
            r = res_q.pop_front();
            checkOutput("key_valid", key_valid, r.kv);
            if (r.kv) checkOutput("key", key, r.key);
        end
    endtask

    // Behavioural cores: fixed latency per chunk, optional hit, two-cycle recovery after abort.
    always @(negedge clk) begin
        core_done  = '0;
        core_found = '0;
        for (int i = 0; i < NC; i++) begin
            if (rst) begin
                busy_m[i]   = 1'b0;
                drain_m[i]  = 0;
                cnt_m[i]    = 0;
                core_rdy[i] = 1'b1;
            end else if (core_abort[i] && busy_m[i]) begin
                busy_m[i]  = 1'b0;
                drain_m[i] = 2;
            end else if (core_en[i]) begin
                busy_m[i]   = 1'b1;
                core_rdy[i] = 1'b0;
                cnt_m[i]    = lat[i];
            end else if (busy_m[i]) begin
                if (cnt_m[i] == 0) begin
                    busy_m[i]              = 1'b0;
                    core_rdy[i]            = 1'b1;
                    core_done[i]           = 1'b1;
                    core_found[i]          = hit[i];
                    core_key[i*KW +: KW]   = hit_key[i];
                end else begin
                    cnt_m[i]--;
                end
            end else if (drain_m[i] != 0) begin
                drain_m[i]--;
                if (drain_m[i] == 0) core_rdy[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            abort_seen = abort_seen | core_abort;
            for (int i = 0; i < NC; i++) begin
                if (core_en[i]) begin
                    if (base_q.size() == 0) checkOutput("unexpected_core_en", core_en, 0);
                    else checkOutput("core_base", core_base[i*KW +: KW], base_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NC; i++) begin
            lat[i] = 3; hit[i] = 1'b0; hit_key[i] = '0;
            busy_m[i] = 1'b0; cnt_m[i] = 0; drain_m[i] = 0;
        end
        repeat (3) @(negedge clk);
        checkOutput("reset_rdy", rdy, 1);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_key_valid", key_valid, 0);
        checkOutput("reset_core_en", core_en, 0);
        checkOutput("reset_key", key, 0);
        checkOutput("reset_core_abort", core_abort, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] exhaustive search with a stray en mid-run");
        lat[0] = 3; lat[1] = 5;
        base_q.push_back(24'h000000); base_q.push_back(24'h400000);
        base_q.push_back(24'h800000); base_q.push_back(24'hC00000);
        res_q.push_back('{kv: 1'b0, key: '0});
        applyStimulus();
        repeat (2) @(negedge clk);
        checkOutput("rdy_low_busy", rdy, 0);
        applyStimulus();
        waitDone();
`ifdef ARC4_DISPATCH_PERF_EN
        checkOutput("perf_chunks", perf_chunks, 4);
`endif
        repeat (3) @(negedge clk);
        checkOutput("done_held", done, 1);

        $display("[TB] core 1 finds key in its first chunk");
        lat[0] = 20; lat[1] = 3; hit[1] = 1'b1; hit_key[1] = 24'h1A2B3C;
        abort_seen = '0;
        base_q.push_back(24'h000000); base_q.push_back(24'h400000);
        res_q.push_back('{kv: 1'b1, key: 24'h1A2B3C});
        applyStimulus();
        checkOutput("done_cleared", done, 0);
        waitDone();
        checkOutput("abort_core0_only", abort_seen, 2'b01);
        checkOutput("cores_rdy_at_done", core_rdy, 2'b11);
        repeat (5) @(negedge clk);
        checkOutput("key_held", key, 24'h1A2B3C);

        $display("[TB] simultaneous hits, lowest index wins");
        lat[0] = 5; lat[1] = 4; hit[0] = 1'b1; hit[1] = 1'b1;
        hit_key[0] = 24'h000011; hit_key[1] = 24'h400022;
        abort_seen = '0;
        base_q.push_back(24'h000000); base_q.push_back(24'h400000);
        res_q.push_back('{kv: 1'b1, key: 24'h000011});
        applyStimulus();
        waitDone();
        checkOutput("no_abort_on_tie", abort_seen, 2'b00);

        $display("[TB] reset mid-dispatch then restart");
        lat[0] = 20; lat[1] = 20; hit[0] = 1'b0; hit[1] = 1'b0;
        base_q.push_back(24'h000000); base_q.push_back(24'h400000);
        applyStimulus();
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_dispatched", base_q.size(), 0);
        rst = 1'b1;
        base_q.delete();
        @(negedge clk);
        checkOutput("midreset_rdy", rdy, 1);
        checkOutput("midreset_key_valid", key_valid, 0);
        checkOutput("midreset_key", key, 0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_core_en", core_en, 0);
        rst = 1'b0;
        @(negedge clk);
        lat[0] = 2; lat[1] = 2;
        base_q.push_back(24'h000000); base_q.push_back(24'h400000);
        base_q.push_back(24'h800000); base_q.push_back(24'hC00000);
        res_q.push_back('{kv: 1'b0, key: '0});
        applyStimulus();
        waitDone();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
